// File: rtl/timer_display_alarm.sv
// Display and alarm side of the timer: double-dabble BCD conversion of the time value,
// a scanned 3-digit 7-segment display with leading-zero blanking, and a timed alarm on done.
module timer_display_alarm #(
    parameter int SCAN_DIV     = 4,
    parameter int ALARM_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  time_in,
    input  logic        done_in,
    input  logic        ack,
    output logic [11:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic [2:0]  an,
    output logic [6:0]  seg,
    output logic        alarm
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int AW = $clog2(ALARM_CYCLES + 1);

    state_t        state, state_nxt;
    logic [19:0]   shift_reg;
    logic [2:0]    shift_cnt;
    logic [7:0]    last_val;
    logic          force_flag;
    logic          start;

    logic [PW-1:0] prescale;
    logic [1:0]    digit;
    logic [3:0]    nibble;
    logic          blank;

    logic [AW-1:0] alarm_cnt;
    logic          done_d;
    logic          done_rise;

    // One double-dabble iteration: correct each BCD nibble, then shift the whole register.
    function automatic logic [19:0] dabble(input logic [19:0] r);
        logic [19:0] t;
        t = r;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5)
                t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign start = (time_in != last_val) || force_flag;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (shift_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            shift_cnt  <= '0;
            last_val   <= '0;
            force_flag <= 1'b1;
            bcd        <= '0;
            bcd_valid  <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shift_reg  <= {12'b0, time_in};
                    shift_cnt  <= '0;
                    force_flag <= 1'b0;
                    last_val   <= time_in;
                end
                SHIFT: begin
                    shift_reg <= dabble(shift_reg);
                    shift_cnt <= shift_cnt + 3'd1;
                end
                DONE: begin
                    bcd       <= shift_reg[19:8];
                    bcd_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            digit    <= '0;
        end else if (prescale == PW'(SCAN_DIV - 1)) begin
            prescale <= '0;
            digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    // Digit select and segment decode depend only on registers; a blanked digit keeps its enable.
    always_comb begin
        an     = 3'b001;
        nibble = bcd[3:0];
        blank  = 1'b0;
        case (digit)
            2'd1: begin
                an     = 3'b010;
                nibble = bcd[7:4];
                blank  = (bcd[11:4] == 8'd0);
            end
            2'd2: begin
                an     = 3'b100;
                nibble = bcd[11:8];
                blank  = (bcd[11:8] == 4'd0);
            end
            default: ;
        endcase
        case (nibble)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank) seg = 7'h00;
    end

    assign done_rise = done_in & ~done_d;

    // A fresh rising edge outranks ack and always reloads the full duration.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_d    <= 1'b0;
            alarm_cnt <= '0;
            alarm     <= 1'b0;
        end else begin
            done_d <= done_in;
            if (done_rise) begin
                alarm_cnt <= AW'(ALARM_CYCLES);
                alarm     <= 1'b1;
            end else if (ack) begin
                alarm_cnt <= '0;
                alarm     <= 1'b0;
            end else if (alarm_cnt != '0) begin
                alarm_cnt <= alarm_cnt - AW'(1);
                alarm     <= (alarm_cnt > AW'(1));
            end else begin
                alarm <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_display_alarm.sv
// Self-checking bench for timer_display_alarm: directed scenarios plus randomized conversions
// and alarm traffic compared against an arithmetic reference model.
module tb_timer_display_alarm;

    localparam int SCAN_DIV     = 4;
    localparam int ALARM_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  time_in;
    logic        done_in;
    logic        ack;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic        busy;
    logic [2:0]  an;
    logic [6:0]  seg;
    logic        alarm;

    int vectors = 0;
    int errors  = 0;
    int last    = 0;

    logic [6:0] seg_lut [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    timer_display_alarm #(.SCAN_DIV(SCAN_DIV), .ALARM_CYCLES(ALARM_CYCLES)) dut (
        .clk(clk), .reset(reset), .time_in(time_in), .done_in(done_in), .ack(ack),
        .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy), .an(an), .seg(seg), .alarm(alarm)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // d: 0 = ones, 1 = tens, 2 = hundreds; leading zeros are dark, ones always lit.
    function automatic logic [6:0] ref_seg(input int v, input int d);
        if (d == 0) return seg_lut[v % 10];
        if (d == 1) return (v < 10) ? 7'h00 : seg_lut[(v / 10) % 10];
        return (v < 100) ? 7'h00 : seg_lut[v / 100];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (!ok && n < limit) begin
            tick();
            n++;
            if (bcd_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int n;
        bit ok;
        reset = 1'b1; time_in = 8'd0; done_in = 1'b0; ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (bcd !== 12'h000) begin errors++; $display("FAIL reset_bcd: got %h want 000", bcd); end
        vectors++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL reset_bcd_valid: got %b want 0", bcd_valid); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (an !== 3'b001) begin errors++; $display("FAIL reset_an: got %b want 001", an); end
        vectors++; if (seg !== 7'h3F) begin errors++; $display("FAIL reset_seg: got %h want 3F", seg); end
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
        reset = 1'b0;
        // time_in equals the reset last_val, so only the forced first conversion can start here.
        tick();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL force_capture_busy: got %b want 1", busy); end
        wait_valid(12, n, ok);
        vectors++; if (!ok || n != 9 || bcd !== 12'h000) begin
            errors++; $display("FAIL force_convert: valid=%b after %0d edges bcd=%h want 9 edges bcd=000", ok, n, bcd);
        end
        tick();
        last = 0;
    endtask

    task automatic test_full_scale;
        time_in = 8'd255;
        tick();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy_e0: got %b want 1", busy); end
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++; if (busy !== 1'b1 || bcd_valid !== 1'b0) begin
                errors++; $display("FAIL fs_busy_e%0d: busy=%b valid=%b want busy=1 valid=0", i, busy, bcd_valid);
            end
        end
        tick();
        vectors++; if (bcd_valid !== 1'b1 || bcd !== ref_bcd(255) || busy !== 1'b0) begin
            errors++; $display("FAIL fs_result: valid=%b bcd=%h busy=%b want 1 %h 0", bcd_valid, bcd, busy, ref_bcd(255));
        end
        tick();
        vectors++; if (bcd_valid !== 1'b0) begin errors++; $display("FAIL fs_valid_pulse: got %b want 0", bcd_valid); end
        last = 255;
    endtask

    task automatic test_blanking(input int v);
        int  n;
        bit  ok;
        int  cnt;
        time_in = 8'(v);
        wait_valid(20, n, ok);
        vectors++; if (!ok || bcd !== ref_bcd(v)) begin
            errors++; $display("FAIL blank_conv_%0d: valid=%b bcd=%h want %h", v, ok, bcd, ref_bcd(v));
        end
        last = v;
        cnt = 0;
        while (an !== 3'b100 && cnt < 20) begin tick(); cnt++; end
        while (an !== 3'b001 && cnt < 40) begin tick(); cnt++; end
        vectors++; if (cnt >= 40) begin errors++; $display("FAIL blank_align_%0d: an=%b never wrapped to 001", v, an); end
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < SCAN_DIV; k++) begin
                vectors++; if (an !== 3'(1 << d) || seg !== ref_seg(v, d)) begin
                    errors++; $display("FAIL blank_%0d_d%0d_c%0d: an=%b seg=%h want an=%b seg=%h",
                                       v, d, k, an, seg, 3'(1 << d), ref_seg(v, d));
                end
                tick();
            end
        end
        vectors++; if (an !== 3'b001) begin errors++; $display("FAIL blank_wrap_%0d: an=%b want 001", v, an); end
    endtask

    task automatic test_change_during_conversion;
        time_in = 8'd100;
        tick();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_capture: busy=%b want 1", busy); end
        tick();
        tick();
        time_in = 8'd37;
        repeat (7) tick();
        vectors++; if (bcd_valid !== 1'b1 || bcd !== ref_bcd(100)) begin
            errors++; $display("FAIL chg_first: valid=%b bcd=%h want 1 %h", bcd_valid, bcd, ref_bcd(100));
        end
        tick();
        vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_recapture: busy=%b want 1", busy); end
        repeat (8) tick();
        vectors++; if (bcd_valid !== 1'b0 || bcd !== ref_bcd(100)) begin
            errors++; $display("FAIL chg_hold: valid=%b bcd=%h want 0 %h", bcd_valid, bcd, ref_bcd(100));
        end
        tick();
        vectors++; if (bcd_valid !== 1'b1 || bcd !== ref_bcd(37)) begin
            errors++; $display("FAIL chg_second: valid=%b bcd=%h want 1 %h", bcd_valid, bcd, ref_bcd(37));
        end
        tick();
        last = 37;
    endtask

    task automatic test_alarm;
        done_in = 1'b0; ack = 1'b0;
        repeat (2) tick();
        done_in = 1'b1;
        tick();
        vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_start: got %b want 1", alarm); end
        for (int i = 1; i < ALARM_CYCLES; i++) begin
            tick();
            vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold_%0d: got %b want 1", i, alarm); end
        end
        tick();
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_expire: got %b want 0", alarm); end
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL alarm_no_retrigger_%0d: got %b want 0", i, alarm); end
        end
        done_in = 1'b0;
        repeat (2) tick();
        done_in = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            tick();
            vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL ack_pre_%0d: got %b want 1", i, alarm); end
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL ack_silence: got %b want 0", alarm); end
        repeat (3) tick();
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL ack_stays_off: got %b want 0", alarm); end
        done_in = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_simultaneous;
        done_in = 1'b1; ack = 1'b1;
        tick();
        ack = 1'b0; done_in = 1'b0;
        vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL sim_edge_wins: got %b want 1", alarm); end
        for (int i = 1; i < ALARM_CYCLES; i++) tick();
        vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL sim_full_len: got %b want 1", alarm); end
        tick();
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL sim_expire: got %b want 0", alarm); end
        repeat (2) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        repeat (5) tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL reload_start: got %b want 1", alarm); end
        for (int i = 7; i <= 21; i++) begin
            tick();
            vectors++; if (alarm !== 1'b1) begin errors++; $display("FAIL reload_hold_e%0d: got %b want 1", i, alarm); end
        end
        tick();
        vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL reload_expire: got %b want 0", alarm); end
    endtask

    task automatic test_random_conversions;
        int  v;
        int  n;
        int  idx;
        bit  ok;
        for (int it = 0; it < 20; it++) begin
            v = int'($urandom_range(0, 255));
            while (v == last) v = int'($urandom_range(0, 255));
            time_in = 8'(v);
            wait_valid(14, n, ok);
            vectors++; if (!ok || n != 10 || bcd !== ref_bcd(v)) begin
                errors++; $display("FAIL rnd_conv_%0d: valid=%b edges=%0d bcd=%h want 1 10 %h", v, ok, n, bcd, ref_bcd(v));
            end
            last = v;
            for (int k = 0; k < 6; k++) begin
                tick();
                case (an)
                    3'b001:  idx = 0;
                    3'b010:  idx = 1;
                    3'b100:  idx = 2;
                    default: idx = -1;
                endcase
                vectors++; if (idx < 0 || seg !== ref_seg(v, idx)) begin
                    errors++; $display("FAIL rnd_seg_%0d: an=%b seg=%h", v, an, seg);
                end
            end
        end
    endtask

    task automatic test_random_alarm;
        int rem;
        bit prev;
        done_in = 1'b0; ack = 1'b0;
        repeat (ALARM_CYCLES + 2) tick();
        rem  = 0;
        prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 5) == 0) done_in = ~done_in;
            ack = ($urandom_range(0, 9) == 0);
            tick();
            if (done_in && !prev) rem = ALARM_CYCLES;
            else if (ack)         rem = 0;
            else if (rem > 0)     rem = rem - 1;
            prev = done_in;
            vectors++; if (alarm !== (rem > 0)) begin
                errors++; $display("FAIL rnd_alarm_c%0d: got %b want %b", c, alarm, rem > 0);
            end
        end
        done_in = 1'b0; ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int v;
        v = (last == 200) ? 201 : 200;
        time_in = 8'(v);
        tick();
        repeat (3) tick();
        done_in = 1'b1;
        tick();
        reset = 1'b1;
        #1;
        vectors++; if (busy !== 1'b0 || bcd !== 12'h000 || bcd_valid !== 1'b0 || alarm !== 1'b0 ||
                        an !== 3'b001 || seg !== 7'h3F) begin
            errors++; $display("FAIL mid_reset: busy=%b bcd=%h valid=%b alarm=%b an=%b seg=%h",
                               busy, bcd, bcd_valid, alarm, an, seg);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        vectors++; if (alarm !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL mid_restart: alarm=%b busy=%b want 1 1", alarm, busy);
        end
        repeat (8) tick();
        vectors++; if (bcd !== 12'h000 || bcd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_partial: bcd=%h valid=%b want 000 0", bcd, bcd_valid);
        end
        tick();
        vectors++; if (bcd_valid !== 1'b1 || bcd !== ref_bcd(v)) begin
            errors++; $display("FAIL mid_reconvert: valid=%b bcd=%h want 1 %h", bcd_valid, bcd, ref_bcd(v));
        end
        done_in = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_scale();
        test_blanking(7);
        test_blanking(40);
        test_change_during_conversion();
        test_alarm();
        test_simultaneous();
        test_random_conversions();
        test_random_alarm();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/timer_display_alarm.md
# timer_display_alarm

Output-side companion to the stopwatch/countdown timer. It samples the timer's 8-bit time value and done flag. It converts the time value to three BCD digits with a sequential double-dabble engine and drives a multiplexed 3-digit 7-segment display with leading-zero blanking. It also raises a timed alarm on each rising edge of done.

## Interface
- SCAN_DIV, default 4: clock cycles each digit stays enabled; legal range ≥1.
- ALARM_CYCLES, default 16: alarm duration in cycles; legal range ≥1.

- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- time_in  input  8  binary time value, connected to the timer time output.
- done_in  input  1  timer done flag (level).
- ack  input  1  silences the alarm.
- bcd  output  12  registered BCD result: [11:8] hundreds, [7:4] tens, [3:0] ones.
- bcd_valid  output  1  one-cycle pulse when bcd updates.
- busy  output  1  high while a conversion is in progress (state ≠ IDLE).
- an  output  3  one-hot digit enable, active-high: 001 = ones, 010 = tens, 100 = hundreds.
- seg  output  7  active-high segments {g,f,e,d,c,b,a}.
- alarm  output  1  alarm drive.

## Operation
- **Conversion FSM:** states IDLE, SHIFT, DONE.
  - **IDLE:** captures time_in when time_in ≠ last_val or force_flag = 1.
    - Loads a 20-bit shift register as {12'b0, time_in}.
    - Clears shift_cnt and force_flag, stores last_val ← time_in, and moves to SHIFT.
  - **SHIFT:** runs one iteration per cycle.
    - Adds 3 to each BCD nibble ≥5, then shifts the whole register left by 1.
    - shift_cnt increments each iteration; after the 8th iteration the FSM moves to DONE.
  - **DONE:** loads bcd ← shift_reg[19:8], pulses bcd_valid, and returns to IDLE.
  - time_in changes during SHIFT or DONE are ignored. The comparison with last_val picks them up on the next IDLE cycle, so the final value is always converted.
  - Results are always valid BCD, 000–255; no saturation is needed.
- **Scan:**
  - A prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→0.
  - an is a one-hot decode of the digit index.
  - seg is the standard decode of the selected nibble (hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble values 10–15 are unreachable; seg = 00 for them.
  - Blanking:
    - The hundreds digit is blanked (seg = 00) when bcd[11:8] = 0.
    - The tens digit is blanked when bcd[11:4] = 0.
    - The ones digit is never blanked.
    - an stays asserted while its digit is blanked.
  - an and seg are combinational from registers only; no input-to-output paths.
- **Alarm:**
  - done_d is a registered copy of done_in. A rising edge is done_in & ~done_d.
  - On a rising edge: alarm_cnt ← ALARM_CYCLES and alarm ← 1.
  - While alarm_cnt > 0, it decrements each cycle; alarm ← 1 while the count after decrement is > 0.
  - ack = 1 clears alarm_cnt and alarm on that edge.
  - A rising edge and ack on the same edge: the rising edge wins and the alarm (re)starts.
  - A rising edge during an active alarm reloads the full duration.
  - The alarm counter width is enough to hold ALARM_CYCLES.

## Timing
- **Reset values:**
  - bcd = 000, bcd_valid = 0, busy = 0, state = IDLE, last_val = 0, force_flag = 1.
  - Prescaler = 0, digit = 0, an = 001, seg = 3F.
  - alarm = 0, alarm_cnt = 0, done_d = 0.
- First IDLE cycle after reset release: converts time_in unconditionally because force_flag = 1.
- If done_in is already high at release, the first edge detects a rising edge and starts the alarm.
- **Conversion latency:** capture at edge E0, shifts at E1..E8, DONE at E9.
  - bcd and bcd_valid update after E9; bcd_valid is low again after E10.
  - busy is high after E0 through E9.
  - The earliest next capture is E10, giving a minimum spacing of 10 cycles between conversions.
- **Scan:** each digit stays enabled for exactly SCAN_DIV cycles. A bcd update takes effect on the current digit immediately.
- **Alarm:** with done_in first sampled high at edge E0, alarm is high after E0 and low after edge E(ALARM_CYCLES). It is high for exactly ALARM_CYCLES cycles.
- **ack:** sampled high at an edge, alarm is low after that edge.
- **Reset mid-conversion or mid-alarm:** all state returns to reset values immediately. A partial result never reaches bcd.

## Test plan
1. **Reset:** assert reset; require every output at its reset value; require an = 001 and seg = 3F.
2. **Full-scale conversion:** time_in = 255 (hex FF) after reset settles; require busy for 9 cycles, then bcd = 12'h255 with one bcd_valid pulse exactly 9 edges after capture.
3. **Blanking:** time_in = 7, SCAN_DIV = 4.
   - Require an cycling 001→010→100, 4 cycles each.
   - Require seg = 07 / 00 / 00 respectively.
   - Repeat with time_in = 40: require seg = 3F / 66 / 00.
4. **Change during conversion:** time_in 100→37 two cycles after capture.
   - Require a first bcd_valid with bcd = 100.
   - Require a second capture on the next IDLE cycle and bcd = 037 after a further 9 edges.
5. **Alarm expiry and ack:**
   - done_in 0→1 with ALARM_CYCLES = 16: require alarm high for exactly 16 cycles and no retrigger while done_in stays high.
   - Repeat with ack pulsed at cycle 5: require alarm low after that edge.
6. **Simultaneous events:** ack high on the same edge as a done_in rising edge; require the alarm to start with the full 16 cycles. A second rising edge mid-alarm reloads the count to 16.
